// File: rtl/clap_axi_pkg.sv
// Shared AXI read-side constants, line-fill FSM encoding and address helpers.
package clap_axi_pkg;

    localparam int unsigned LINE_WORDS_DEFAULT = 16;
    localparam logic [2:0]  AXI_SIZE_WORD      = 3'b010;
    localparam logic [1:0]  AXI_BURST_INCR     = 2'b01;
    localparam logic [1:0]  AXI_RESP_OKAY      = 2'b00;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAr     = 2'd1,
        StRecv   = 2'd2,
        StFinish = 2'd3
    } rd_state_e;

    // Cached fills always start on a 64-byte boundary.
    function automatic logic [31:0] line_align(input logic [31:0] addr);
        return {addr[31:6], 6'b0};
    endfunction

endpackage

// File: rtl/rd_buffer_axi_reg.sv
// Enabled register with asynchronous active-low clear; used for request latching.
module rd_buffer_axi_reg #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/rd_buffer_axi.sv
// AXI read buffer: issues one INCR burst per cache fill and assembles beats into r_line.
// Define CLAP_RD_RRESP_CHECK_EN to report non-OKAY rresp on rd_err (otherwise rd_err is 0).
module rd_buffer_axi
    import clap_axi_pkg::*;
#(
    parameter int unsigned LINE_WORDS = LINE_WORDS_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     rd_req,
    input  logic [31:0]              rd_addr,
    input  logic                     uncache,
    output logic                     arvalid,
    input  logic                     arready,
    output logic [31:0]              araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [31:0]              rdata,
    input  logic                     rlast,
    input  logic [1:0]               rresp,
    output logic [32*LINE_WORDS-1:0] r_line,
    output logic                     rd_finish,
    input  logic                     rd_reset,
    output logic                     rd_err
);

    localparam int unsigned     CNT_W   = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LINE_WORDS - 1);

    rd_state_e        state_q;
    logic [CNT_W-1:0] count_q;
    logic [32:0]      req_q;
    logic [31:0]      addr_q;
    logic             uncache_q;
    logic             req_accept;
    logic             beat_ok;

    assign req_accept = (state_q == StIdle) && rd_req;
    assign beat_ok    = rvalid && rready;

    rd_buffer_axi_reg #(
        .WIDTH (33)
    ) u_req_reg (
        .clk  (clk),
        .rstn (rstn),
        .en   (req_accept),
        .d    ({uncache, rd_addr}),
        .q    (req_q)
    );

    assign addr_q    = req_q[31:0];
    assign uncache_q = req_q[32];

    // Address channel fields come straight from the latch, so they hold while arvalid waits.
    assign araddr  = uncache_q ? addr_q : line_align(addr_q);
    assign arlen   = uncache_q ? 8'd0 : 8'(LINE_WORDS - 1);
    assign arsize  = AXI_SIZE_WORD;
    assign arburst = AXI_BURST_INCR;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            count_q   <= '0;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            rd_finish <= 1'b0;
            r_line    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rd_req) begin
                        state_q <= StAr;
                        arvalid <= 1'b1;
                        count_q <= '0;
                    end
                end
                StAr: begin
                    if (arready) begin
                        state_q <= StRecv;
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                    end
                end
                StRecv: begin
                    if (beat_ok) begin
                        r_line[{count_q, 5'b0} +: 32] <= rdata;
                        // Overlong bursts keep overwriting the last word rather than wrapping.
                        if (count_q != CNT_MAX) begin
                            count_q <= count_q + 1'b1;
                        end
                        if (rlast) begin
                            state_q   <= StFinish;
                            rready    <= 1'b0;
                            rd_finish <= 1'b1;
                        end
                    end
                end
                StFinish: begin
                    if (rd_reset) begin
                        state_q   <= StIdle;
                        rd_finish <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

`ifdef CLAP_RD_RRESP_CHECK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if (req_accept) begin
            err_q <= 1'b0;
        end else if (state_q == StRecv && beat_ok && rresp != AXI_RESP_OKAY) begin
            err_q <= 1'b1;
        end
    end

    assign rd_err = err_q;
`else
    logic unused_rresp;

    assign unused_rresp = ^rresp;
    assign rd_err       = 1'b0;
`endif

endmodule

// File: tb/tb_rd_buffer_axi.sv
// Randomised bench for rd_buffer_axi: a transaction-level model is compared every cycle.
module tb_rd_buffer_axi;

    localparam int unsigned LW = 16;
`ifdef CLAP_RD_RRESP_CHECK_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic            clk;
    logic            rstn;
    logic            rd_req;
    logic [31:0]     rd_addr;
    logic            uncache;
    logic            arvalid;
    logic            arready;
    logic [31:0]     araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            rvalid;
    logic            rready;
    logic [31:0]     rdata;
    logic            rlast;
    logic [1:0]      rresp;
    logic [32*LW-1:0] r_line;
    logic            rd_finish;
    logic            rd_reset;
    logic            rd_err;

    int n_chk;
    int n_fail;
    bit cmp_en;

    rd_buffer_axi #(
        .LINE_WORDS (LW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .uncache   (uncache),
        .arvalid   (arvalid),
        .arready   (arready),
        .araddr    (araddr),
        .arlen     (arlen),
        .arsize    (arsize),
        .arburst   (arburst),
        .rvalid    (rvalid),
        .rready    (rready),
        .rdata     (rdata),
        .rlast     (rlast),
        .rresp     (rresp),
        .r_line    (r_line),
        .rd_finish (rd_finish),
        .rd_reset  (rd_reset),
        .rd_err    (rd_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_line(input string name, input logic [32*LW-1:0] act,
                            input logic [32*LW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: 0 waiting, 1 address, 2 data, 3 line ready.
    int          m_phase;
    logic [31:0] m_addr;
    logic        m_unc;
    logic [31:0] m_words [LW];
    int          m_idx;
    logic        m_err;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_phase <= 0;
            m_addr  <= '0;
            m_unc   <= 1'b0;
            m_idx   <= 0;
            m_err   <= 1'b0;
            for (int i = 0; i < LW; i++) m_words[i] <= '0;
        end else if (m_phase == 0) begin
            if (rd_req) begin
                m_addr  <= rd_addr;
                m_unc   <= uncache;
                m_idx   <= 0;
                m_err   <= 1'b0;
                m_phase <= 1;
            end
        end else if (m_phase == 1) begin
            if (arready) m_phase <= 2;
        end else if (m_phase == 2) begin
            if (rvalid) begin
                m_words[m_idx] <= rdata;
                m_idx <= (m_idx + 1 < LW) ? m_idx + 1 : LW - 1;
                if (ERR_EN && rresp != 2'b00) m_err <= 1'b1;
                if (rlast) m_phase <= 3;
            end
        end else begin
            if (rd_reset) m_phase <= 0;
        end
    end

    logic [32*LW-1:0] exp_line;

    always_comb begin
        exp_line = '0;
        for (int i = 0; i < LW; i++) exp_line[32*i +: 32] = m_words[i];
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("arvalid", {63'd0, arvalid}, {63'd0, m_phase == 1});
            chk("rready", {63'd0, rready}, {63'd0, m_phase == 2});
            chk("rd_finish", {63'd0, rd_finish}, {63'd0, m_phase == 3});
            chk("rd_err", {63'd0, rd_err}, {63'd0, m_err});
            chk_line("r_line", r_line, exp_line);
            if (m_phase == 1) begin
                chk("araddr", {32'd0, araddr},
                    {32'd0, m_unc ? m_addr : (m_addr & 32'hFFFF_FFC0)});
                chk("arlen", {56'd0, arlen}, {56'd0, m_unc ? 8'd0 : 8'(LW - 1)});
                chk("arsize", {61'd0, arsize}, 64'd2);
                chk("arburst", {62'd0, arburst}, 64'd1);
            end
        end
    end

    // gap_mode: 0 back-to-back, 1 one idle cycle before each beat, 2 random gaps and noise.
    task automatic fill(input logic [31:0] addr, input logic unc, input int nbeats,
                        input bit give_last, input int ar_delay, input int gap_mode,
                        input int err_beat, input logic [31:0] base, input bit chk_ar,
                        input logic [31:0] exp_araddr, input logic [7:0] exp_arlen);
        rd_req  = 1'b1;
        rd_addr = addr;
        uncache = unc;
        @(posedge clk); #1;
        rd_req  = 1'b0;
        rd_addr = $urandom;
        uncache = 1'($urandom_range(0, 1));
        if (chk_ar) begin
            chk("ar_valid_lit", {63'd0, arvalid}, 64'd1);
            chk("ar_addr_lit", {32'd0, araddr}, {32'd0, exp_araddr});
            chk("ar_len_lit", {56'd0, arlen}, {56'd0, exp_arlen});
            chk("ar_err_clear", {63'd0, rd_err}, 64'd0);
        end
        for (int d = 0; d < ar_delay; d++) begin
            rvalid = 1'($urandom_range(0, 1));
            rdata  = $urandom;
            @(posedge clk); #1;
        end
        rvalid  = 1'b0;
        arready = 1'b1;
        @(posedge clk); #1;
        arready = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            int gaps;
            gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gaps; g++) begin
                rvalid = 1'b0;
                rdata  = $urandom;
                rlast  = 1'($urandom_range(0, 1));
                rresp  = 2'($urandom);
                if (gap_mode == 2) rd_req = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            rvalid = 1'b1;
            rdata  = base + 32'(b);
            rlast  = give_last && (b == nbeats - 1);
            rresp  = (b == err_beat) ? 2'b10 : 2'b00;
            @(posedge clk); #1;
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
        rdata  = '0;
        rd_req = 1'b0;
    endtask

    task automatic ack(input int hold);
        repeat (hold) begin
            @(posedge clk); #1;
        end
        rd_reset = 1'b1;
        @(posedge clk); #1;
        rd_reset = 1'b0;
    endtask

    task automatic chk_words(input string name, input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            chk(name, {32'd0, r_line[32*i +: 32]}, {32'd0, base + 32'(i)});
        end
    endtask

    initial begin
        n_chk    = 0;
        n_fail   = 0;
        cmp_en   = 1'b0;
        rstn     = 1'b0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        uncache  = 1'b0;
        arready  = 1'b0;
        rvalid   = 1'b0;
        rdata    = '0;
        rlast    = 1'b0;
        rresp    = 2'b00;
        rd_reset = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        cmp_en = 1'b1;
        chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("rst_rready", {63'd0, rready}, 64'd0);
        chk("rst_finish", {63'd0, rd_finish}, 64'd0);
        chk("rst_err", {63'd0, rd_err}, 64'd0);
        chk_line("rst_line", r_line, '0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Cached 16-beat fill.
        fill(32'h1C00_0134, 1'b0, 16, 1'b1, 2, 0, -1, 32'h100, 1'b1, 32'h1C00_0100, 8'd15);
        chk("cached_finish", {63'd0, rd_finish}, 64'd1);
        chk_words("cached_word", 32'h100, 16);
        ack(2);

        // Uncached single beat.
        fill(32'hBFD0_0004, 1'b1, 1, 1'b1, 0, 0, -1, 32'hDEAD_BEEF, 1'b1, 32'hBFD0_0004, 8'd0);
        chk("unc_finish", {63'd0, rd_finish}, 64'd1);
        chk("unc_word0", {32'd0, r_line[31:0]}, 64'hDEAD_BEEF);
        ack(1);

        // Backpressure: beat every other cycle with junk data in between.
        fill(32'h1C00_0134, 1'b0, 16, 1'b1, 1, 1, -1, 32'h100, 1'b1, 32'h1C00_0100, 8'd15);
        chk("bp_finish", {63'd0, rd_finish}, 64'd1);
        chk_words("bp_word", 32'h100, 16);

        // rd_req while finished, then rd_req together with rd_reset: both dropped.
        rd_req  = 1'b1;
        rd_addr = 32'h0000_1000;
        @(posedge clk); #1;
        rd_req = 1'b0;
        chk("fin_req_ignored", {63'd0, arvalid}, 64'd0);
        chk("fin_still_done", {63'd0, rd_finish}, 64'd1);
        rd_req   = 1'b1;
        rd_reset = 1'b1;
        @(posedge clk); #1;
        rd_req   = 1'b0;
        rd_reset = 1'b0;
        chk("ack_req_finish", {63'd0, rd_finish}, 64'd0);
        chk("ack_req_noar", {63'd0, arvalid}, 64'd0);
        @(posedge clk); #1;
        chk("ack_req_noar2", {63'd0, arvalid}, 64'd0);

        // Overlong burst saturates on the last word.
        fill(32'h0000_2040, 1'b0, 18, 1'b1, 0, 0, -1, 32'h300, 1'b1, 32'h0000_2040, 8'd15);
        chk_words("sat_word", 32'h300, 15);
        chk("sat_last", {32'd0, r_line[32*15 +: 32]}, 64'h311);
        ack(0);

        // Early rlast ends the fill after four beats.
        fill(32'h0000_3000, 1'b0, 4, 1'b1, 1, 0, -1, 32'h400, 1'b0, '0, '0);
        chk("early_finish", {63'd0, rd_finish}, 64'd1);
        chk_words("early_word", 32'h400, 4);
        chk("early_keep4", {32'd0, r_line[32*4 +: 32]}, 64'h304);
        ack(1);

        // Reset in the middle of a burst.
        fill(32'h0000_4000, 1'b0, 5, 1'b0, 0, 0, -1, 32'h500, 1'b0, '0, '0);
        rstn = 1'b0;
        #1;
        chk("mid_rst_rready", {63'd0, rready}, 64'd0);
        chk("mid_rst_arvalid", {63'd0, arvalid}, 64'd0);
        chk_line("mid_rst_line", r_line, '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(posedge clk); #1;
        fill(32'h0000_5010, 1'b0, 16, 1'b1, 0, 0, -1, 32'h200, 1'b1, 32'h0000_5000, 8'd15);
        chk_words("post_rst_word", 32'h200, 16);
        ack(1);

        // Error response on the third beat.
        fill(32'h0000_6000, 1'b0, 16, 1'b1, 0, 0, 2, 32'h600, 1'b1, 32'h0000_6000, 8'd15);
        chk("err_finish", {63'd0, rd_finish}, 64'd1);
        chk("err_set", {63'd0, rd_err}, {63'd0, ERR_EN});
        ack(2);
        fill(32'h0000_7000, 1'b1, 1, 1'b1, 0, 0, -1, 32'h700, 1'b1, 32'h0000_7000, 8'd0);
        ack(0);

        for (int it = 0; it < 30; it++) begin
            logic        unc;
            int          nb;
            unc = 1'($urandom_range(0, 1));
            nb  = unc ? 1 : int'($urandom_range(1, LW + 2));
            fill($urandom, unc, nb, 1'b1, int'($urandom_range(0, 3)), 2,
                 int'($urandom_range(0, nb)) - 1, $urandom, 1'b0, '0, '0);
            ack(int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
